lab3_b_exhaustive_checker: RTL and testbench
============================================

// Module: lab3_b_exhaustive_checker
// PURPOSE
//  Stimulus/response end of the lab3_b 4-input logic function: drives all 16 input vectors
//  {x,y,z,w} in ascending order and samples the function output for each one.
//  Compares each sample against a parameterised truth table, counts mismatches, records the first failure.
//  Sits beside the lab3_b instance on the lab board/bench; start/done handshake to a controller.
// PARAMETERS
//  EXPECTED  16'hC0F7  truth table, bit i = expected outb for vector i = {x,y,z,w} (x = MSB)
//  SETTLE    2         cycles each vector is held before sampling; legal range 1..15, elaboration error otherwise
// PORTS
//  CL2947MP_clk         in   1  single clock, all state on rising edge
//  CL2947MP_rst_n       in   1  asynchronous, active-low reset
//  CL2947MP_start       in   1  begin a run; honoured only in IDLE
//  CL2947MP_abort       in   1  terminate a run; return to IDLE without done
//  CL2947MP_outb        in   1  response from the lab3_b function under test
//  CL2947MP_x/_y/_z/_w  out  1  registered stimulus = idx[3]/idx[2]/idx[1]/idx[0]
//  CL2947MP_busy        out  1  high in APPLY/CHECK
//  CL2947MP_done        out  1  one-cycle pulse on run completion
//  CL2947MP_pass        out  1  1 iff the last completed run had zero mismatches
//  CL2947MP_err_count   out  5  mismatches in current/last run, 0..16
//  CL2947MP_fail_seen   out  1  at least one mismatch recorded this run
//  CL2947MP_first_fail  out  4  index of first mismatching vector; valid when fail_seen
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, idx=0 (x,y,z,w=0), settle cnt=0, busy=0, done=0, pass=0,
//   err_count=0, fail_seen=0, first_fail=0. Takes effect immediately, including mid-run.
//  States: IDLE, APPLY, CHECK, DONE.
//  IDLE: start=1 at an edge -> APPLY; idx=0, cnt=0, err_count=0, fail_seen=0, first_fail=0, pass=0.
//  APPLY: vector idx is driven; cnt increments each cycle; after SETTLE cycles (cnt==SETTLE-1) -> CHECK.
//  CHECK: one cycle; outb sampled at the edge leaving CHECK and compared to EXPECTED[idx].
//   On mismatch: err_count+1; if !fail_seen, first_fail=idx and fail_seen=1.
//   If idx==15 -> DONE (idx holds 15), else idx+1, cnt=0 -> APPLY. idx never wraps within a run.
//  DONE: one cycle; done=1, busy=0, pass=(final err_count==0, including the last CHECK); -> IDLE.
//  Each vector is held SETTLE+1 cycles. start at edge t gives done high during cycle t+16*(SETTLE+1)+1
//   (cycle t+49 at default).
//  start in APPLY/CHECK/DONE is ignored (no restart, no queueing).
//  abort has priority over start and over CHECK sampling: in APPLY/CHECK -> IDLE next edge;
//   the in-flight sample is discarded; no done, pass=0. err_count/fail_seen/first_fail keep partial values.
//  abort in IDLE/DONE has no effect; DONE completes normally.
//  Results (pass, err_count, fail_seen, first_fail) hold in IDLE until the next accepted start.
//  err_count is 5 bits; the 16-mismatch maximum fits, no saturation logic required.
// STRUCTURE
//  Shared package lab3_pkg: state enum (IDLE/APPLY/CHECK/DONE), LAB3_B_TRUTH = 16'hC0F7
//   (f = x'z' + x'w' + yz), vector width 4.
//  Single module: FSM, 4-bit idx, 4-bit settle counter, result registers. No sub-module.
//  lab3_b is instantiated alongside, not inside.
// TESTING
//  1 Good DUT (lab3_b wired to ports), SETTLE=2, start at t -> done at t+49, pass=1, err_count=0, fail_seen=0.
//  2 outb tied 0 -> err_count=9, first_fail=0, pass=0; outb tied 1 -> err_count=7, first_fail=3.
//  3 Inverted DUT -> err_count=16, first_fail=0, pass=0; good DUT with only vector 14 flipped -> err_count=1, first_fail=14.
//  4 Vector sequence: {x,y,z,w} steps 0..15, each value held exactly 3 cycles; x/y/z/w stable through CHECK.
//  5 start pulsed at idx=7 -> ignored, run length unchanged; abort at idx=5 -> busy=0 next cycle,
//    no done pulse, pass=0; new start then runs clean.
//  6 rst_n low mid-CHECK between edges -> all outputs to reset values immediately; release, start -> normal pass.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared definitions for the lab3_b function and its exhaustive checker:
// reference truth table, vector width and checker FSM state codes.
package lab3_pkg;

  localparam int VEC_W = 4;

  // Bit i is the expected outb for input vector i = {x,y,z,w}, x as MSB.
  localparam logic [15:0] LAB3_B_TRUTH = 16'hC0F7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/lab3_b_exhaustive_checker.sv
// Exhaustive stimulus/response checker for the 4-input lab3_b function: walks all
// 16 vectors, samples outb after a settle time, counts mismatches and records the first.
module lab3_b_exhaustive_checker
  import lab3_pkg::*;
#(
  parameter logic [15:0] EXPECTED = LAB3_B_TRUTH,
  parameter int          SETTLE   = 2
) (
  input  logic       CL2947MP_clk,
  input  logic       CL2947MP_rst_n,
  input  logic       CL2947MP_start,
  input  logic       CL2947MP_abort,
  input  logic       CL2947MP_outb,
  output logic       CL2947MP_x,
  output logic       CL2947MP_y,
  output logic       CL2947MP_z,
  output logic       CL2947MP_w,
  output logic       CL2947MP_busy,
  output logic       CL2947MP_done,
  output logic       CL2947MP_pass,
  output logic [4:0] CL2947MP_err_count,
  output logic       CL2947MP_fail_seen,
  output logic [3:0] CL2947MP_first_fail
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("lab3_b_exhaustive_checker: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]       state;
  logic [VEC_W-1:0] idx;
  logic [3:0]       cnt;
  logic             mismatch;
  logic [4:0]       err_next;

  assign mismatch = (CL2947MP_outb != EXPECTED[idx]);
  assign err_next = CL2947MP_err_count + {4'd0, mismatch};

  // abort is tested before any sampling so an aborted CHECK leaves the results untouched
  always_ff @(posedge CL2947MP_clk or negedge CL2947MP_rst_n) begin
    if (!CL2947MP_rst_n) begin
      state               <= ST_IDLE;
      idx                 <= '0;
      cnt                 <= '0;
      CL2947MP_pass       <= 1'b0;
      CL2947MP_err_count  <= '0;
      CL2947MP_fail_seen  <= 1'b0;
      CL2947MP_first_fail <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CL2947MP_start) begin
            state               <= ST_APPLY;
            idx                 <= '0;
            cnt                 <= '0;
            CL2947MP_pass       <= 1'b0;
            CL2947MP_err_count  <= '0;
            CL2947MP_fail_seen  <= 1'b0;
            CL2947MP_first_fail <= '0;
          end
        end
        ST_APPLY: begin
          if (CL2947MP_abort) begin
            state         <= ST_IDLE;
            CL2947MP_pass <= 1'b0;
          end else if (cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          if (CL2947MP_abort) begin
            state         <= ST_IDLE;
            CL2947MP_pass <= 1'b0;
          end else begin
            CL2947MP_err_count <= err_next;
            if (mismatch && !CL2947MP_fail_seen) begin
              CL2947MP_first_fail <= idx;
              CL2947MP_fail_seen  <= 1'b1;
            end
            if (idx == 4'd15) begin
              state         <= ST_DONE;
              CL2947MP_pass <= (err_next == 5'd0);
            end else begin
              idx   <= idx + 4'd1;
              cnt   <= '0;
              state <= ST_APPLY;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign CL2947MP_x    = idx[3];
  assign CL2947MP_y    = idx[2];
  assign CL2947MP_z    = idx[1];
  assign CL2947MP_w    = idx[0];
  assign CL2947MP_busy = (state == ST_APPLY) || (state == ST_CHECK);
  assign CL2947MP_done = (state == ST_DONE);

endmodule

// File: tb/tb_lab3_b_exhaustive_checker.sv
// Randomized self-checking bench for lab3_b_exhaustive_checker; the function under
// test is modelled as a response table indexed by the driven vector.
module tb_lab3_b_exhaustive_checker;

  localparam logic [15:0] EXP     = 16'hC0F7;
  localparam int          RUN_LEN = 48;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       outb;
  logic       x, y, z, w;
  logic       busy, done, pass, fail_seen;
  logic [4:0] err_count;
  logic [3:0] first_fail;
  logic [15:0] resp_table;
  logic [3:0]  vec;

  int checks   = 0;
  int failures = 0;

  lab3_b_exhaustive_checker #(.EXPECTED(EXP), .SETTLE(2)) dut (
    .CL2947MP_clk       (clk),
    .CL2947MP_rst_n     (rst_n),
    .CL2947MP_start     (start),
    .CL2947MP_abort     (abort),
    .CL2947MP_outb      (outb),
    .CL2947MP_x         (x),
    .CL2947MP_y         (y),
    .CL2947MP_z         (z),
    .CL2947MP_w         (w),
    .CL2947MP_busy      (busy),
    .CL2947MP_done      (done),
    .CL2947MP_pass      (pass),
    .CL2947MP_err_count (err_count),
    .CL2947MP_fail_seen (fail_seen),
    .CL2947MP_first_fail(first_fail)
  );

  assign vec  = {x, y, z, w};
  assign outb = resp_table[vec];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int popcnt16(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int first_one(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full run against a response table; expectations come from the XOR with the truth table.
  task automatic run_full(input logic [15:0] tbl, input string name);
    int n;
    int exp_err;
    int exp_first;
    logic [15:0] diff;
    resp_table = tbl;
    diff      = tbl ^ EXP;
    exp_err   = popcnt16(diff);
    exp_first = first_one(diff);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n !== RUN_LEN) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, RUN_LEN);
    end
    checks++;
    if (err_count !== 5'(exp_err)) begin
      failures++;
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err);
    end
    checks++;
    if (pass !== (exp_err == 0)) begin
      failures++;
      $display("FAIL %s pass: got %b expected %b", name, pass, exp_err == 0);
    end
    checks++;
    if (fail_seen !== (exp_err != 0)) begin
      failures++;
      $display("FAIL %s fail_seen: got %b expected %b", name, fail_seen, exp_err != 0);
    end
    checks++;
    if (first_fail !== 4'(exp_first)) begin
      failures++;
      $display("FAIL %s first_fail: got %0d expected %0d", name, first_fail, exp_first);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== (exp_err == 0) || err_count !== 5'(exp_err)) begin
      failures++;
      $display("FAIL %s idle_hold: done=%b busy=%b pass=%b err=%0d expected done=0 busy=0 pass=%b err=%0d",
               name, done, busy, pass, err_count, exp_err == 0, exp_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    resp_table = EXP;
    #2;
    checks++;
    if ({busy, done, pass, err_count, fail_seen, first_fail, vec} !== 17'd0) begin
      failures++;
      $display("FAIL reset_values: got %h expected 0",
               {busy, done, pass, err_count, fail_seen, first_fail, vec});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_good_run;
    run_full(EXP, "good");
  endtask

  task automatic test_fault_tables;
    logic [15:0] flip14;
    flip14 = EXP ^ 16'h4000;
    run_full(16'h0000, "tie0");
    run_full(16'hFFFF, "tie1");
    run_full(~EXP, "inverted");
    run_full(flip14, "flip14");
  endtask

  task automatic test_random_tables;
    logic [15:0] tbl;
    for (int r = 0; r < 6; r++) begin
      tbl = 16'($urandom);
      run_full(tbl, $sformatf("random%0d", r));
    end
  endtask

  // Each vector must appear in ascending order for exactly three consecutive cycles.
  task automatic test_vector_sequence;
    int bad = 0;
    int first_bad = -1;
    resp_table = EXP;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < RUN_LEN; k++) begin
      if (vec !== 4'(k / 3) || busy !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL vector_sequence: %0d bad samples, first at cycle %0d", bad, first_bad);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL vector_sequence done: got %b expected 1", done);
    end
    tick();
  endtask

  task automatic test_start_ignored;
    int n = 0;
    bit pulsed = 0;
    logic [15:0] tbl;
    tbl = EXP ^ 16'h0210;
    resp_table = tbl;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 200) begin
      if (vec == 4'd7 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      tick();
      start = 1'b0;
      n++;
    end
    checks++;
    if (n !== RUN_LEN || !pulsed) begin
      failures++;
      $display("FAIL start_ignored latency: got %0d expected %0d", n, RUN_LEN);
    end
    checks++;
    if (err_count !== 5'd2 || first_fail !== 4'd4) begin
      failures++;
      $display("FAIL start_ignored results: err=%0d first=%0d expected err=2 first=4",
               err_count, first_fail);
    end
    tick();
  endtask

  // Abort once vector 5 is on the pins: only vectors 0..4 have been checked.
  task automatic test_abort;
    int n = 0;
    int done_seen = 0;
    logic [15:0] tbl;
    logic [15:0] part;
    tbl = 16'($urandom);
    part = (tbl ^ EXP) & 16'h001F;
    resp_table = tbl;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (vec != 4'd5 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (vec !== 4'd5) begin
      failures++;
      $display("FAIL abort reach_vec5: got %0d expected 5", vec);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort busy: got %b expected 0", busy);
    end
    for (int k = 0; k < 60; k++) begin
      if (done) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL abort no_done: done pulses=%0d pass=%b expected 0 0", done_seen, pass);
    end
    checks++;
    if (err_count !== 5'(popcnt16(part)) || fail_seen !== (part != 0) ||
        first_fail !== 4'(first_one(part))) begin
      failures++;
      $display("FAIL abort partial: err=%0d seen=%b first=%0d expected err=%0d seen=%b first=%0d",
               err_count, fail_seen, first_fail, popcnt16(part), part != 0, first_one(part));
    end
    run_full(EXP, "after_abort");
  endtask

  // Reset asserted between edges during vector 4's CHECK cycle.
  task automatic test_async_reset;
    run_full(EXP, "pre_reset");
    resp_table = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (vec !== 4'd4 || err_count !== 5'd1 || first_fail !== 4'd3) begin
      failures++;
      $display("FAIL async_reset precondition: vec=%0d err=%0d first=%0d expected 4 1 3",
               vec, err_count, first_fail);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, err_count, fail_seen, first_fail, vec} !== 17'd0) begin
      failures++;
      $display("FAIL async_reset values: got %h expected 0",
               {busy, done, pass, err_count, fail_seen, first_fail, vec});
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_full(EXP, "post_reset");
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_fault_tables();
    test_random_tables();
    test_vector_sequence();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
